// File: rtl/ex_operand_stage_if.sv
// Bundled decode-side, forwarding-bus and ALU-side signals of the execute operand stage.
interface ex_operand_stage_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_W  = 3,
  parameter int unsigned OP_W   = 4
);
  localparam int unsigned SH_W = $clog2(DATA_W) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [REG_W-1:0]  in_src_a;
  logic [REG_W-1:0]  in_src_b;
  logic [DATA_W-1:0] in_rdata_a;
  logic [DATA_W-1:0] in_rdata_b;
  logic [REG_W-1:0]  in_dest;
  logic              in_we;

  logic              ex_fwd_we;
  logic [REG_W-1:0]  ex_fwd_dest;
  logic [DATA_W-1:0] ex_fwd_data;
  logic              wb_fwd_we;
  logic [REG_W-1:0]  wb_fwd_dest;
  logic [DATA_W-1:0] wb_fwd_data;

  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_op;
  logic [REG_W-1:0]  out_dest;
  logic              out_we;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic              out_b_zero;
  logic [SH_W-1:0]   out_shamt;

  modport slave (
    input  in_valid, in_op, in_src_a, in_src_b, in_rdata_a, in_rdata_b, in_dest, in_we,
    input  ex_fwd_we, ex_fwd_dest, ex_fwd_data, wb_fwd_we, wb_fwd_dest, wb_fwd_data,
    input  out_ready,
    output in_ready, out_valid, out_op, out_dest, out_we, out_a, out_b, out_b_zero, out_shamt
  );

  modport master (
    output in_valid, in_op, in_src_a, in_src_b, in_rdata_a, in_rdata_b, in_dest, in_we,
    output ex_fwd_we, ex_fwd_dest, ex_fwd_data, wb_fwd_we, wb_fwd_dest, wb_fwd_data,
    output out_ready,
    input  in_ready, out_valid, out_op, out_dest, out_we, out_a, out_b, out_b_zero, out_shamt
  );
endinterface

// File: rtl/ex_operand_stage.sv
// Execute-entry operand stage: 2-entry skid FIFO with operand forwarding and shift-amount precompute.
// Optional feature macro: OPFWD_FORWARDING_EN enables EX/WB forwarding and WB snooping of held entries.
module ex_operand_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_W  = 3,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  ex_operand_stage_if.slave bus
);
  localparam int unsigned SH_W = $clog2(DATA_W) + 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  dest;
    logic              we;
    logic [REG_W-1:0]  src_a;
    logic [REG_W-1:0]  src_b;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              b_zero;
    logic [SH_W-1:0]   shamt;
  } t_entry;

  t_entry            r_e0, r_e1;
  t_entry            w_e0_nxt, w_e1_nxt, w_new, w_s0, w_s1;
  logic [1:0]        r_count, w_count_nxt;
  logic              r_in_ready, r_out_valid;
  logic              w_accept, w_retire;
  logic [DATA_W-1:0] w_a, w_b;

  // Position of least-significant one plus one; zero for a zero operand.
  function automatic logic [SH_W-1:0] f_shamt(input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] lsb;
    logic [SH_W-1:0]   s;
    lsb = b & (~b + DATA_W'(1));
    s   = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (lsb == (DATA_W'(1) << i)) s = SH_W'(i + 1);
    end
    return s;
  endfunction

  function automatic t_entry f_set_b(input t_entry e, input logic [DATA_W-1:0] b);
    t_entry r;
    r        = e;
    r.b      = b;
    r.b_zero = (b == '0);
    r.shamt  = f_shamt(b);
    return r;
  endfunction

`ifdef OPFWD_FORWARDING_EN
  function automatic logic [DATA_W-1:0] f_resolve(
    input logic [REG_W-1:0]  src,     input logic [DATA_W-1:0] rdata,
    input logic              ex_we,   input logic [REG_W-1:0]  ex_dest,
    input logic [DATA_W-1:0] ex_data, input logic              wb_we,
    input logic [REG_W-1:0]  wb_dest, input logic [DATA_W-1:0] wb_data
  );
    if (src == '0)                    return '0;
    else if (ex_we && ex_dest == src) return ex_data;
    else if (wb_we && wb_dest == src) return wb_data;
    else                              return rdata;
  endfunction

  // Held entries pick up WB results for their sources; EX is resolved only at accept.
  function automatic t_entry f_snoop(
    input t_entry e, input logic we, input logic [REG_W-1:0] dest, input logic [DATA_W-1:0] data
  );
    t_entry r;
    r = e;
    if (we && dest == e.src_a && e.src_a != '0) r.a = data;
    if (we && dest == e.src_b && e.src_b != '0) r = f_set_b(r, data);
    return r;
  endfunction

  assign w_a  = f_resolve(bus.in_src_a, bus.in_rdata_a, bus.ex_fwd_we, bus.ex_fwd_dest,
                          bus.ex_fwd_data, bus.wb_fwd_we, bus.wb_fwd_dest, bus.wb_fwd_data);
  assign w_b  = f_resolve(bus.in_src_b, bus.in_rdata_b, bus.ex_fwd_we, bus.ex_fwd_dest,
                          bus.ex_fwd_data, bus.wb_fwd_we, bus.wb_fwd_dest, bus.wb_fwd_data);
  assign w_s0 = f_snoop(r_e0, bus.wb_fwd_we, bus.wb_fwd_dest, bus.wb_fwd_data);
  assign w_s1 = f_snoop(r_e1, bus.wb_fwd_we, bus.wb_fwd_dest, bus.wb_fwd_data);
`else
  logic w_unused_fwd;

  assign w_a  = (bus.in_src_a == '0) ? '0 : bus.in_rdata_a;
  assign w_b  = (bus.in_src_b == '0) ? '0 : bus.in_rdata_b;
  assign w_s0 = r_e0;
  assign w_s1 = r_e1;
  assign w_unused_fwd = ^{bus.ex_fwd_we, bus.ex_fwd_dest, bus.ex_fwd_data,
                          bus.wb_fwd_we, bus.wb_fwd_dest, bus.wb_fwd_data};
`endif

  assign w_accept = bus.in_valid && r_in_ready && !flush;
  assign w_retire = r_out_valid && bus.out_ready;

  always_comb begin
    w_new       = '0;
    w_new.op    = bus.in_op;
    w_new.dest  = bus.in_dest;
    w_new.we    = bus.in_we;
    w_new.src_a = bus.in_src_a;
    w_new.src_b = bus.in_src_b;
    w_new.a     = w_a;
    w_new       = f_set_b(w_new, w_b);
  end

  // FIFO next state; entry 0 is always the head driving the ALU.
  always_comb begin
    w_e0_nxt    = w_s0;
    w_e1_nxt    = w_s1;
    w_count_nxt = r_count;
    case (r_count)
      2'd0: begin
        if (w_accept) begin
          w_e0_nxt    = w_new;
          w_count_nxt = 2'd1;
        end
      end
      2'd1: begin
        if (w_retire && w_accept) begin
          w_e0_nxt = w_new;
        end else if (w_retire) begin
          w_count_nxt = 2'd0;
        end else if (w_accept) begin
          w_e1_nxt    = w_new;
          w_count_nxt = 2'd2;
        end
      end
      default: begin
        if (w_retire) begin
          w_e0_nxt    = w_s1;
          w_count_nxt = 2'd1;
        end
      end
    endcase
    if (flush) w_count_nxt = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e0        <= '0;
      r_e0.b_zero <= 1'b1;
      r_e1        <= '0;
      r_e1.b_zero <= 1'b1;
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_e0        <= w_e0_nxt;
      r_e1        <= w_e1_nxt;
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != 2'd2);
      r_out_valid <= (w_count_nxt != 2'd0);
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_op     = r_e0.op;
  assign bus.out_dest   = r_e0.dest;
  assign bus.out_we     = r_e0.we;
  assign bus.out_a      = r_e0.a;
  assign bus.out_b      = r_e0.b;
  assign bus.out_b_zero = r_e0.b_zero;
  assign bus.out_shamt  = r_e0.shamt;
endmodule
